serial_tx_scheduler: RTL and testbench
======================================

# serial_tx_scheduler

Round-robin scheduler that shares a single serial output line among `NREQ` requesters. It accepts one parallel word at a time through a valid/ready handshake and loads it into a parallel-in/serial-out shift register. It then shifts the word out LSB-first with a frame strobe and inserts a programmable inter-frame gap. It sits between the parallel producers and the serial link in the shift-register datapath.

## Interface
Parameters:
- `WIDTH`, default 8: bits per frame (≥2).
- `NREQ`, default 2: number of requesters (≥1).
- `GAP`, default 1: idle cycles after each frame (≥0).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NREQ: requester i has a word pending.
- `req_data`  in  NREQ*WIDTH: word of requester i at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ: one-hot accept; transfer occurs when `req_valid[i] & req_ready[i]` at a rising edge.
- `serial_out`  out  1: current serial bit; 0 when not framing.
- `frame`  out  1: high exactly while `serial_out` carries data bits.
- `busy`  out  1: high in SHIFT and GAP.
- `grant_id`  out  clog2(NREQ) (min 1): index of the requester owning the current or last frame.

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE:**
  - Select the first i with `req_valid[i]`, searching from the round-robin pointer `ptr` upward with wrap-around.
  - `req_ready[i]` is combinational from state, `req_valid` and `ptr`; it is high only in IDLE and only for the selected i.
  - On the accepting edge:
    - Load `req_data[i]` into the shift register.
    - `grant_id` ← i.
    - `ptr` ← (i+1) mod NREQ.
    - Bit counter ← 0.
    - Go to SHIFT.
  - If there is no valid request, stay in IDLE.
- **SHIFT:**
  - `serial_out` = shreg[0] and `frame` = 1.
  - Each edge shifts right (shreg ← {0, shreg[WIDTH-1:1]}) and increments the counter.
  - After the WIDTH-th bit, go to GAP if GAP>0, otherwise go to IDLE.
- **GAP:**
  - `serial_out` = 0 and `frame` = 0.
  - The counter runs GAP cycles, then the state goes to IDLE.
- Requests asserted during SHIFT/GAP get no ready; they wait until IDLE.
- Requesters hold `req_valid` and `req_data` stable until accepted. The block samples `req_data` only on the accepting edge.
- `req_data` of non-selected requesters is ignored.

## Timing
- Reset value of every output and register:
  - `req_ready` = 0, `serial_out` = 0, `frame` = 0, `busy` = 0, `grant_id` = 0.
  - `ptr` = 0, state = IDLE, shift register and counter = 0.
- Latency: accept at edge k → bit0 on `serial_out`, with `frame`=1, in the cycle after edge k.
- Frame occupies exactly WIDTH cycles.
- Minimum request-to-request period is WIDTH+GAP+1 cycles (one IDLE cycle always separates frames).
- Reset is asserted during low `rst_n` at an edge. Reset mid-frame or mid-gap:
  - The frame is aborted at that edge and all outputs take reset values the next cycle.
  - The in-flight word is lost and is not re-requested by the block.
- `req_ready` is forced 0 whenever `rst_n`=0.
- With all requesters valid continuously, grants cycle 0,1,…,NREQ-1,0.
- With NREQ=1, `ptr` is always 0.

## Structure
- Shared package `serial_tx_pkg`:
  - State enum (IDLE/SHIFT/GAP).
  - Width helper constants for the counter (clog2 of max(WIDTH,GAP)+1) and `grant_id`.
- Sub-module `piso_shift_reg`: WIDTH-bit parallel-load, right-shift register with `load`, `shift` and synchronous active-low clear; LSB is the output.
- Arbitration pointer, FSM and counter live in the top.

## Test plan
(WIDTH=8, NREQ=2, GAP=1 unless noted)
1. Reset: hold `rst_n`=0 for 3 cycles with `req_valid`=2'b11 → `req_ready`=0, `serial_out`=0, `frame`=0, `busy`=0, `grant_id`=0 throughout.
2. Single request:
   - Stimulus: `req_valid[0]`=1, data 8'hA5.
   - Response: `req_ready`=2'b01 for one cycle; then `serial_out` = 1,0,1,0,0,1,0,1 over 8 cycles with `frame`=1 and `grant_id`=0.
   - Then 1 GAP cycle (`frame`=0, `busy`=1), then IDLE.
3. Contention:
   - Stimulus: both valid continuously, data0=8'h0F, data1=8'hF0.
   - Response: grants alternate 0,1,0,1; frame starts are exactly 10 cycles apart; bit patterns match the LSB-first expansion.
4. Late request: `req_valid[1]` rises during SHIFT of a req0 frame → `req_ready[1]` stays 0 until IDLE, then is granted.
5. Reset mid-frame:
   - Stimulus: drop `rst_n` after 3 bits of 8'hFF.
   - Response: next cycle `frame`=0 and `serial_out`=0; after release with both valid, the first grant goes to req0.
6. GAP=0 build: back-to-back requests → frames separated by exactly one IDLE cycle (period 9).

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding and width helpers for the serial tx scheduler
package serial_tx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
  function automatic int cnt_w(input int width, input int gap);
    return $clog2((width > gap ? width : gap) + 1);
  endfunction
  function automatic int id_w(input int nreq);
    return nreq > 1 ? $clog2(nreq) : 1;
  endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load right-shift register, LSB is the serial output
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  logic [WIDTH-1:0] sh_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= '0;
    else if (load_i) sh_q <= data_i;
    else if (shift_i) sh_q <= {1'b0, sh_q[WIDTH-1:1]};
  end
  assign bit_o = sh_q[0];
endmodule

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter feeding a framed LSB-first serial line with inter-frame gap
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int GAP   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        serial_out,
  output logic                        frame,
  output logic                        busy,
  output logic [id_w(NREQ)-1:0]       grant_id
);
  localparam int CW = cnt_w(WIDTH, GAP);
  localparam int IW = id_w(NREQ);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP > 0 ? GAP - 1 : 0);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, sel, idx;
  logic found, accept, sh_bit;
  // first valid requester at or after ptr, wrapping around
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == ST_IDLE && found) req_ready[sel] = 1'b1;
  end
  assign accept = |req_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_SHIFT;
        cnt_d = '0;
        ptr_d = IW'((int'(sel) + 1) % NREQ);
        gid_d = sel;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q == BIT_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q == BIT_LAST) state_d = GAP > 0 ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        cnt_d = cnt_q == GAP_LAST ? '0 : cnt_q + CW'(1);
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
    end
  end
  piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(accept),
    .shift_i(state_q == ST_SHIFT),
    .data_i(req_data[int'(sel)*WIDTH +: WIDTH]),
    .bit_o(sh_bit)
  );
  assign serial_out = state_q == ST_SHIFT ? sh_bit : 1'b0;
  assign frame = state_q == ST_SHIFT;
  assign busy = state_q != ST_IDLE;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed checks of arbitration, framing, gap and reset for two GAP builds
module tb_serial_tx_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] vld = 2'b11, g_vld = 2'b00;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic [1:0] ready, g_ready;
  logic ser, frm, bsy, g_ser, g_frm, g_bsy;
  logic [0:0] gid, g_gid;
  int checks = 0, errors = 0, cyc = 0, last = 0;
  always #5 clk = ~clk;
  serial_tx_scheduler #(.WIDTH(8), .NREQ(2), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_data({d1, d0}),
    .req_ready(ready), .serial_out(ser), .frame(frm), .busy(bsy), .grant_id(gid)
  );
  serial_tx_scheduler #(.WIDTH(8), .NREQ(2), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .req_valid(g_vld), .req_data({d1, d0}),
    .req_ready(g_ready), .serial_out(g_ser), .frame(g_frm), .busy(g_bsy), .grant_id(g_gid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_frame(input logic [7:0] d, input logic id);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bit%0d", i), ser, d[i]);
      chk("frame_hi", frm, 1);
      chk("busy_shift", bsy, 1);
      chk("gid", gid, id);
      step();
    end
  endtask
  task automatic reset_pulse();
    rst_n = 0;
    vld = 2'b00;
    step();
    rst_n = 1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", ready, 0);
      chk("rst_ser", ser, 0);
      chk("rst_frame", frm, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_gid", gid, 0);
    end
    rst_n = 1; vld = 2'b01; d0 = 8'hA5;
    #1 chk("single_ready", ready, 2'b01);
    step();
    vld = 2'b00;
    chk("single_ready_drop", ready, 0);
    chk_frame(8'hA5, 0);
    chk("gap_frame", frm, 0);
    chk("gap_busy", bsy, 1);
    chk("gap_ser", ser, 0);
    step();
    chk("idle_busy", bsy, 0);
    chk("idle_ready", ready, 0);
    reset_pulse();
    vld = 2'b11; d0 = 8'h0F; d1 = 8'hF0;
    #1 chk("cont_ready0", ready, 2'b01);
    for (int f = 0; f < 4; f++) begin
      step();
      if (f == 3) vld = 2'b00;
      if (f > 0) chk("period10", cyc - last, 10);
      last = cyc;
      chk_frame(f % 2 ? 8'hF0 : 8'h0F, f[0]);
      chk("cont_gap", bsy & ~frm, 1);
      step();
      chk("cont_idle", bsy, 0);
      if (f < 3) chk("cont_next_ready", ready, f % 2 ? 2'b01 : 2'b10);
    end
    vld = 2'b01; d0 = 8'h3C; d1 = 8'hC3;
    #1 chk("late_ready0", ready, 2'b01);
    step();
    vld = 2'b10;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("late_bit%0d", i), ser, d0[i]);
      chk("late_no_ready", ready, 0);
      step();
    end
    chk("late_gap_no_ready", ready, 0);
    step();
    chk("late_idle_ready", ready, 2'b10);
    step();
    vld = 2'b00;
    chk_frame(8'hC3, 1);
    step();
    vld = 2'b01; d0 = 8'hFF;
    #1 chk("mid_ready", ready, 2'b01);
    step();
    vld = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("mid_bit", ser, 1);
      if (i < 2) step();
    end
    rst_n = 0; vld = 2'b11;
    #1 chk("rst_forces_ready0", ready, 0);
    step();
    chk("abort_frame", frm, 0);
    chk("abort_ser", ser, 0);
    chk("abort_busy", bsy, 0);
    rst_n = 1;
    #1 chk("post_rst_ready", ready, 2'b01);
    step();
    vld = 2'b00;
    chk_frame(8'hFF, 0);
    step();
    g_vld = 2'b01; d0 = 8'h5A;
    #1 chk("g0_ready", g_ready, 2'b01);
    for (int f = 0; f < 3; f++) begin
      step();
      if (f == 2) g_vld = 2'b00;
      if (f > 0) chk("g0_period9", cyc - last, 9);
      last = cyc;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("g0_bit%0d", i), g_ser, d0[i]);
        chk("g0_frame", g_frm, 1);
        step();
      end
      chk("g0_idle_frame", g_frm, 0);
      chk("g0_idle_busy", g_bsy, 0);
      if (f < 2) chk("g0_idle_ready", g_ready, 2'b01);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
